mips_cpu_lsu_bus: RTL and testbench
===================================

# mips_cpu_lsu_bus

Multi-cycle load/store unit for the MIPS CPU. It sits between the execute stage and the Avalon-style data memory port. It accepts one memory instruction at a time and computes the effective address. It then drives byte-enabled bus reads and writes, honouring `avm_waitrequest`, and returns aligned, sign/zero-extended or merged load data. This block adds a proper bus handshake, byte enables, misalignment detection and an optional read-modify-write path for sub-word stores.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: width of `avm_address`. Bus address is the low `ADDR_WIDTH` bits of the effective address.
- `CHECK_ALIGN`, default 1:
  - 1: misaligned LW/SW/LH/LHU/SH return an error.
  - 0: offending low address bits are ignored.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `op` in 6: MIPS opcode. LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
- `base` in 32: rs value.
- `offset` in 16: immediate, sign-extended.
- `store_data` in 32: rt value for stores.
- `rt_old` in 32: current rt, used for the LWL/LWR merge.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: load result. 0 for stores and errors.
- `resp_error` out 1: qualifies `resp_valid`. Set for misalignment or an unsupported `op`.
- `avm_address` out ADDR_WIDTH: word-aligned address, low 2 bits 0.
- `avm_read` out 1, `avm_write` out 1: bus strobes.
- `avm_byteenable` out 4: byte lanes enabled for the access.
- `avm_writedata` out 32: write data.
- `avm_readdata` in 32: read data.
- `avm_waitrequest` in 1: stall; hold all bus outputs while high.

## Operation

- Effective address `ea = base + sext(offset)`; `k = ea[1:0]`.
- Byte lanes are little-endian: byte at offset k occupies bits `8k+7:8k`.
- On acceptance (`req_valid && req_ready` at a rising edge), `op`, `ea`, `store_data` and `rt_old` are registered. Later input changes are ignored.
- FSM states:
  - IDLE: `req_ready`=1. On accept:
    - error → RESP.
    - load, or sub-word store with `MIPS_LSU_RMW_EN` defined → READ.
    - otherwise → WRITE.
  - READ: `avm_read`=1 until a cycle with `avm_waitrequest`=0. `avm_readdata` is captured in that cycle. Next state is RESP for a load, WRITE for an RMW store.
  - WRITE: `avm_write`=1 until a cycle with `avm_waitrequest`=0, then → RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then → IDLE.
- Load results (w = captured word):
  - LW: w.
  - LB/LBU: `w[8k+7:8k]`, sign- or zero-extended.
  - LH/LHU: `w[16*k[1]+15 : 16*k[1]]`, sign- or zero-extended.
  - LWL: `(w << 8(3-k)) | (rt_old & (2^(8(3-k)) - 1))`.
  - LWR: `(w >> 8k) | (rt_old & ~(2^(32-8k) - 1))`. At k=0 the result is w.
- Direct-write byte enables and write data:
  - SW: byteenable 1111, data `store_data`.
  - SH: byteenable 0011 or 1100 selected by `k[1]`, data `{2{store_data[15:0]}}`.
  - SB: byteenable `1<<k`, data `{4{store_data[7:0]}}`.
  - Loads drive byteenable 1111.
- Alignment:
  - Error when `CHECK_ALIGN`=1 and either condition holds: LW/SW with k≠0, or LH/LHU/SH with k[0]=1.
  - An unsupported `op` is always an error.
  - An error issues no bus cycle.
- Reset mid-operation: state forced to IDLE immediately. Bus strobes and `resp_valid` drop asynchronously and the transaction is abandoned.

## Timing

- Reset values:
  - `req_ready`=1.
  - `resp_valid`, `resp_error`, `avm_read`, `avm_write` = 0.
  - `resp_data`, `avm_address`, `avm_writedata` = 0.
  - `avm_byteenable` = 0000.
- Latency counts edges after the accepting edge, with N = wait-state cycles:
  - Load or direct store: `resp_valid` high in cycle 2+N.
  - RMW store: `resp_valid` high in cycle 3+N_read+N_write.
  - Error: `resp_valid` high in cycle 1.
- Bus outputs are registered and stable for the whole strobe, including all waitrequest cycles.
- `avm_read` and `avm_write` are never high together.
- Back-to-back: `req_ready` returns high the cycle after RESP. Maximum throughput is one access per 3 cycles.

## Configuration

- `MIPS_LSU_RMW_EN` defined:
  - SB/SH perform READ of the aligned word.
  - The target byte or halfword is merged into the read data.
  - The merged word is then written in WRITE with byteenable 1111.
  - This mode is for memories without byte enables.
- `MIPS_LSU_RMW_EN` undefined: SB/SH issue a single WRITE with partial byteenable. No read is issued.

## Test plan

- LW, base=0x100, offset=4, readdata=0xDEADBEEF, zero wait states:
  - Cycle 1: address 0x104, read=1, byteenable 1111.
  - Cycle 2: resp_data=0xDEADBEEF.
- LB at 0x103 with readdata=0x80FF0000 → resp_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, store_data=0x1234ABCD, waitrequest high for 3 cycles:
  - address 0x200, byteenable 1100, writedata 0xABCDABCD held for 4 cycles.
  - resp_valid in cycle 5.
- LWL at 0x001, readdata=0x44332211, rt_old=0xAABBCCDD → 0x2211CCDD. LWR at 0x002 with the same inputs → 0xAABB4433.
- LW at 0x102 with CHECK_ALIGN=1 → resp_valid+resp_error in cycle 1, no avm_read.
- With `MIPS_LSU_RMW_EN`: SB at 0x301, store_data=0x5A, readdata=0x11223344 → write 0x11225A44 with byteenable 1111. Assert reset during WRITE → avm_write low immediately and req_ready=1.

Source files
------------

// File: rtl/mips_cpu_lsu_bus_if.sv
// Bundle of the load/store unit's request/response handshake and its
// Avalon-style data memory port.
//   master : the load/store unit (accepts requests, returns responses,
//            drives the memory strobes, address, byte enables and write data)
//   slave  : the environment (execute stage issuing requests plus the memory
//            answering with readdata/waitrequest)
// Parameter ADDR_WIDTH sets the width of avm_address.
interface mips_cpu_lsu_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // request / response side
    logic                  req_valid;
    logic                  req_ready;
    logic [5:0]            op;
    logic [31:0]           base;
    logic [15:0]           offset;
    logic [31:0]           store_data;
    logic [31:0]           rt_old;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_error;

    // memory side
    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [3:0]            avm_byteenable;
    logic [31:0]           avm_writedata;
    logic [31:0]           avm_readdata;
    logic                  avm_waitrequest;

    modport master (
        input  req_valid, op, base, offset, store_data, rt_old,
        input  avm_readdata, avm_waitrequest,
        output req_ready, resp_valid, resp_data, resp_error,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );

    modport slave (
        output req_valid, op, base, offset, store_data, rt_old,
        output avm_readdata, avm_waitrequest,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );
endinterface

// File: rtl/mips_cpu_lsu_bus.sv
// Multi-cycle MIPS load/store unit with an Avalon-style data port.
// Accepts one memory instruction at a time, forms ea = base + sext(offset),
// runs a byte-enabled bus read and/or write honouring avm_waitrequest and
// returns extended or merged load data with a one-cycle resp_valid pulse.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : mips_cpu_lsu_bus_if.master (request/response + avm_* port)
// Parameters:
//   ADDR_WIDTH  : width of avm_address (low bits of the effective address)
//   CHECK_ALIGN : 1 flags misaligned LW/SW/LH/LHU/SH, 0 ignores the low bits
// Build option:
//   MIPS_LSU_RMW_EN : when defined, SB/SH become read-modify-write of the
//                     aligned word with a full-word write (no byte enables
//                     needed in memory); otherwise they are a single write
//                     with partial byte enables.
module mips_cpu_lsu_bus #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_lsu_bus_if.master bus
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

`ifdef MIPS_LSU_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                state;

    // registered outputs
    logic                  req_ready;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_error;
    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_read;
    logic                  avm_write;
    logic [3:0]            avm_byteenable;
    logic [31:0]           avm_writedata;

    // request captured at acceptance
    logic [5:0]            op_q;
    logic [1:0]            k_q;
    logic [31:0]           rt_old_q;
    logic [15:0]           sd_q;

    // decode of the incoming request
    logic [31:0]           ea;
    logic [1:0]            k;
    logic                  op_ok;
    logic                  misalign;
    logic                  is_load;
    logic                  is_sub_store;
    logic                  req_err;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;

    // Classify the request, flag errors and prepare direct-write lanes/data
    always_comb begin
        ea           = bus.base + {{16{bus.offset[15]}}, bus.offset};
        k            = ea[1:0];
        op_ok        = 1'b1;
        misalign     = 1'b0;
        is_load      = 1'b0;
        is_sub_store = 1'b0;
        wr_be        = 4'b1111;
        wr_data      = bus.store_data;
        case (bus.op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: begin
                is_load = 1'b1;
            end
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                misalign = k[0];
            end
            OP_LW: begin
                is_load  = 1'b1;
                misalign = (k != 2'b00);
            end
            OP_SB: begin
                is_sub_store = 1'b1;
                wr_be        = 4'b0001 << k;
                wr_data      = {4{bus.store_data[7:0]}};
            end
            OP_SH: begin
                is_sub_store = 1'b1;
                misalign     = k[0];
                wr_be        = k[1] ? 4'b1100 : 4'b0011;
                wr_data      = {2{bus.store_data[15:0]}};
            end
            OP_SW: begin
                misalign = (k != 2'b00);
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
        req_err = !op_ok || (CHECK_ALIGN && misalign);
    end

    // Lane-select, extend or merge the captured read word for a load.
    // 3-k equals ~k for a 2-bit k, so the LWL shift is {~k, 3'b000}.
    function automatic logic [31:0] load_fmt(
        input logic [5:0]  f_op,
        input logic [1:0]  f_k,
        input logic [31:0] w,
        input logic [31:0] rt
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {f_k, 3'b000});
        h = 16'(w >> {f_k[1], 4'b0000});
        case (f_op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LWL:  r = (w << {~f_k, 3'b000}) |
                         (rt & ~(32'hFFFF_FFFF << {~f_k, 3'b000}));
            OP_LWR:  r = (w >> {f_k, 3'b000}) |
                         (rt & ~(32'hFFFF_FFFF >> {f_k, 3'b000}));
            default: r = w;
        endcase
        return r;
    endfunction

    // Drop the stored byte/halfword into the word read back for RMW
    function automatic logic [31:0] rmw_merge(
        input logic [5:0]  f_op,
        input logic [1:0]  f_k,
        input logic [31:0] w,
        input logic [15:0] sd
    );
        logic [31:0] r;
        r = w;
        if (f_op == OP_SB) begin
            r[{f_k, 3'b000} +: 8] = sd[7:0];
        end else begin
            r[{f_k[1], 4'b0000} +: 16] = sd;
        end
        return r;
    endfunction

    // Control FSM; every output is a register so the bus stays stable
    // across waitrequest and drops straight away on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_data      <= 32'h0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= 32'h0;
            op_q           <= 6'h0;
            k_q            <= 2'b00;
            rt_old_q       <= 32'h0;
            sd_q           <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= bus.op;
                        k_q       <= k;
                        rt_old_q  <= bus.rt_old;
                        sd_q      <= bus.store_data[15:0];
                        if (req_err) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= 32'h0;
                        end else begin
                            avm_address <= ADDR_WIDTH'({ea[31:2], 2'b00});
                            if (is_load || (RMW_EN && is_sub_store)) begin
                                state          <= S_READ;
                                avm_read       <= 1'b1;
                                avm_byteenable <= 4'b1111;
                            end else begin
                                state          <= S_WRITE;
                                avm_write      <= 1'b1;
                                avm_byteenable <= wr_be;
                                avm_writedata  <= wr_data;
                            end
                        end
                    end
                end

                S_READ: begin
                    if (!bus.avm_waitrequest) begin
                        avm_read <= 1'b0;
                        // loads are 100xxx, stores 101xxx
                        if (!op_q[3]) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_data  <= load_fmt(op_q, k_q, bus.avm_readdata, rt_old_q);
                        end else begin
                            state          <= S_WRITE;
                            avm_write      <= 1'b1;
                            avm_byteenable <= 4'b1111;
                            avm_writedata  <= rmw_merge(op_q, k_q, bus.avm_readdata, sd_q);
                        end
                    end
                end

                S_WRITE: begin
                    if (!bus.avm_waitrequest) begin
                        avm_write  <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_data  <= 32'h0;
                    end
                end

                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.resp_valid     = resp_valid;
    assign bus.resp_data      = resp_data;
    assign bus.resp_error     = resp_error;
    assign bus.avm_address    = avm_address;
    assign bus.avm_read       = avm_read;
    assign bus.avm_write      = avm_write;
    assign bus.avm_byteenable = avm_byteenable;
    assign bus.avm_writedata  = avm_writedata;

endmodule

// File: tb/tb_mips_cpu_lsu_bus.sv
// Self-checking bench for mips_cpu_lsu_bus: directed scenarios plus random
// accesses checked cycle by cycle against a byte-level reference model.
module tb_mips_cpu_lsu_bus;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LWL = 6'b100010;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LWR = 6'b100110;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

`ifdef MIPS_LSU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mips_cpu_lsu_bus_if #(.ADDR_WIDTH(32)) bus ();

    mips_cpu_lsu_bus #(
        .ADDR_WIDTH  (32),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour derived from byte lanes and plain arithmetic
    function automatic void ref_model(
        input  logic [5:0]  op,
        input  logic [31:0] ea,
        input  logic [31:0] sd,
        input  logic [31:0] rt,
        input  logic [31:0] w,
        output bit          err,
        output bit          rd,
        output bit          wr,
        output logic [3:0]  be_w,
        output logic [31:0] wd,
        output logic [31:0] res
    );
        int unsigned k;
        int unsigned hk;
        int unsigned sh;
        int unsigned hv;
        logic [7:0]  by [4];
        bit          ld;
        bit          st;
        longint unsigned wl;
        longint unsigned rl;
        k  = ea % 4;
        hk = (k / 2) * 2;
        for (int i = 0; i < 4; i++) by[i] = 8'((w >> (8 * i)) & 32'hFF);
        ld  = (op == LB) || (op == LH) || (op == LWL) || (op == LW) ||
              (op == LBU) || (op == LHU) || (op == LWR);
        st  = (op == SB) || (op == SH) || (op == SW);
        err = !(ld || st) ||
              (((op == LW) || (op == SW)) && k != 0) ||
              (((op == LH) || (op == LHU) || (op == SH)) && (k % 2) != 0);
        rd   = !err && (ld || (RMW && (op == SB || op == SH)));
        wr   = !err && st;
        be_w = 4'hF;
        wd   = sd;
        res  = 32'h0;
        wl   = longint'(w);
        rl   = longint'(rt);
        hv   = by[hk] + 256 * by[hk + 1];
        if (op == SH) begin
            be_w = (k >= 2) ? 4'b1100 : 4'b0011;
            wd   = sd[15:0] * 32'h0001_0001;
        end else if (op == SB) begin
            be_w = 4'(1 << k);
            wd   = sd[7:0] * 32'h0101_0101;
        end
        if (RMW && (op == SB || op == SH)) begin
            if (op == SB) begin
                by[k] = sd[7:0];
            end else begin
                by[hk]     = sd[7:0];
                by[hk + 1] = sd[15:8];
            end
            be_w = 4'hF;
            wd   = {by[3], by[2], by[1], by[0]};
        end
        if (!err && ld) begin
            case (op)
                LB:  res = (by[k] >= 128) ? 32'(by[k]) - 32'd256 : 32'(by[k]);
                LBU: res = 32'(by[k]);
                LH:  res = (hv >= 32768) ? 32'(hv) - 32'd65536 : 32'(hv);
                LHU: res = 32'(hv);
                LWL: begin
                    sh  = 8 * (3 - k);
                    res = 32'((wl << sh) | (rl & ((64'd1 << sh) - 1)));
                end
                LWR: begin
                    sh  = 8 * k;
                    res = 32'((wl >> sh) | (rl & ~((64'd1 << (32 - sh)) - 1)));
                end
                default: res = w;
            endcase
        end
    endfunction

    // One strobe phase: nw wait cycles then the completing cycle
    task automatic bus_phase(input string tag, input bit is_wr, input logic [31:0] addr,
                             input int nw, input logic [3:0] be, input logic [31:0] wd,
                             input logic [31:0] rdata);
        for (int i = 0; i <= nw; i++) begin
            check({tag, "_read"},  32'(bus.avm_read),  32'(!is_wr));
            check({tag, "_write"}, 32'(bus.avm_write), 32'(is_wr));
            check({tag, "_addr"},  bus.avm_address, addr);
            check({tag, "_be"},    32'(bus.avm_byteenable), 32'(be));
            if (is_wr) check({tag, "_wdata"}, bus.avm_writedata, wd);
            check({tag, "_rvalid_low"}, 32'(bus.resp_valid), 32'd0);
            bus.avm_waitrequest = (i < nw);
            bus.avm_readdata    = (i == nw) ? rdata : $urandom;
            @(negedge clk);
        end
        bus.avm_waitrequest = 1'b0;
    endtask

    // Issue one request at a negedge and follow it to completion
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] base_v,
                          input logic [15:0] off_v, input logic [31:0] sd, input logic [31:0] rt,
                          input logic [31:0] w, input int nwr, input int nww,
                          output logic [31:0] got);
        logic [31:0] ea;
        logic [31:0] addr;
        bit          err, rd, wr;
        logic [3:0]  be_w;
        logic [31:0] wd, res;
        ea   = base_v + 32'(int'($signed(off_v)));
        addr = ea - (ea % 4);
        ref_model(op, ea, sd, rt, w, err, rd, wr, be_w, wd, res);
        check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid       = 1'b1;
        bus.op              = op;
        bus.base            = base_v;
        bus.offset          = off_v;
        bus.store_data      = sd;
        bus.rt_old          = rt;
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.op         = 6'($urandom);
        bus.base       = $urandom;
        bus.offset     = 16'($urandom);
        bus.store_data = $urandom;
        bus.rt_old     = $urandom;
        if (rd) bus_phase({tag, "_rd"}, 1'b0, addr, nwr, 4'hF, 32'h0, w);
        if (wr) bus_phase({tag, "_wr"}, 1'b1, addr, nww, be_w, wd, 32'h0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_resp_error"}, 32'(bus.resp_error), 32'(err));
        check({tag, "_resp_data"},  bus.resp_data, res);
        check({tag, "_no_strobe"},  32'({bus.avm_read, bus.avm_write}), 32'd0);
        check({tag, "_ready_resp"}, 32'(bus.req_ready), 32'd0);
        got = bus.resp_data;
        @(negedge clk);
        check({tag, "_pulse_end"},  32'(bus.resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [5:0]  ops [11];
        logic [5:0]  op;
        logic [31:0] b;
        logic [15:0] o;
        n_cmp = 0;
        n_bad = 0;
        ops = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW, 6'b101111};

        reset               = 1'b1;
        bus.req_valid       = 1'b0;
        bus.op              = 6'h0;
        bus.base            = 32'h0;
        bus.offset          = 16'h0;
        bus.store_data      = 32'h0;
        bus.rt_old          = 32'h0;
        bus.avm_readdata    = 32'h0;
        bus.avm_waitrequest = 1'b0;
        #1;
        check("rst_ready",  32'(bus.req_ready), 32'd1);
        check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        check("rst_rerror", 32'(bus.resp_error), 32'd0);
        check("rst_rdata",  bus.resp_data, 32'h0);
        check("rst_strobe", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("rst_addr",   bus.avm_address, 32'h0);
        check("rst_be",     32'(bus.avm_byteenable), 32'd0);
        check("rst_wdata",  bus.avm_writedata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // directed scenarios
        run_op("lw",   LW,  32'h100, 16'h0004, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0, got);
        check("lw_val", got, 32'hDEADBEEF);
        run_op("lb",   LB,  32'h103, 16'h0000, 32'h0, 32'h0, 32'h80FF0000, 0, 0, got);
        check("lb_val", got, 32'hFFFFFF80);
        run_op("lbu",  LBU, 32'h103, 16'h0000, 32'h0, 32'h0, 32'h80FF0000, 1, 0, got);
        check("lbu_val", got, 32'h00000080);
        run_op("sh",   SH,  32'h202, 16'h0000, 32'h1234ABCD, 32'h0, 32'h55667788, 2, 3, got);
        run_op("lwl",  LWL, 32'h001, 16'h0000, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0, got);
        check("lwl_val", got, 32'h2211CCDD);
        run_op("lwr",  LWR, 32'h002, 16'h0000, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0, got);
        check("lwr_val", got, 32'hAABB4433);
        run_op("lwr0", LWR, 32'h010, 16'h0000, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0, got);
        run_op("lwl3", LWL, 32'h013, 16'h0000, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, 0, got);
        run_op("mis",  LW,  32'h102, 16'h0000, 32'h0, 32'h0, 32'h12345678, 0, 0, got);
        run_op("mish", SH,  32'h101, 16'h0000, 32'h0, 32'h0, 32'h12345678, 0, 0, got);
        run_op("badop", 6'b000000, 32'h100, 16'h0, 32'h0, 32'h0, 32'h0, 0, 0, got);
        run_op("sb",   SB,  32'h301, 16'h0000, 32'h5A, 32'h0, 32'h11223344, 1, 2, got);
        run_op("negoff", LHU, 32'h1000, 16'hFFFE, 32'h0, 32'h0, 32'h9ABC1234, 0, 1, got);
        check("negoff_val", got, 32'h00009ABC);

        // random accesses, half of them forced word-aligned
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 10)];
            b  = $urandom;
            o  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                b = b & 32'hFFFF_FFFC;
                o = o & 16'hFFFC;
            end
            run_op("rnd", op, b, o, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), got);
        end

        // reset in the middle of a write strobe
        bus.req_valid       = 1'b1;
        bus.op              = SW;
        bus.base            = 32'h400;
        bus.offset          = 16'h0;
        bus.store_data      = 32'hCAFEF00D;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_write_on", 32'(bus.avm_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_write_drop", 32'(bus.avm_write), 32'd0);
        check("mid_ready",      32'(bus.req_ready), 32'd1);
        check("mid_rvalid",     32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset               = 1'b0;
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'({bus.avm_read, bus.avm_write, bus.resp_valid}), 32'd0);
        run_op("post", LW, 32'h500, 16'h0008, 32'h0, 32'h0, 32'h0BADF00D, 1, 0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
